// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's imem/dmem ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic [15:0]       imem_addr;
  logic              imem_oe;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic [31:0]       dmem_addr;
  logic              dmem_oe;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_we;
  logic [31:0]       dmem_rdata;
  logic              dmem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_oe;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport slave (
    input  imem_addr, imem_oe, dmem_addr, dmem_oe, dmem_wdata, dmem_we,
           mem_rdata, mem_ready,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready,
           mem_addr, mem_oe, mem_wdata, mem_we
  );

  modport master (
    output imem_addr, imem_oe, dmem_addr, dmem_oe, dmem_wdata, dmem_we,
           mem_rdata, mem_ready,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready,
           mem_addr, mem_oe, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between imem and dmem: dmem has fixed priority,
// and imem is forced through after STARVE_MAX consecutive lost cycles.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM  = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0] STARVE_ZERO = {STARVE_W{1'b0}};
  localparam logic [STARVE_W-1:0] STARVE_ONE  = STARVE_W'(1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  owner_e              owner_r, owner_s;
  logic [STARVE_W-1:0] starve_r, starve_s;
  logic                ireq_r, dreq_r;
  logic [ADDR_W-1:0]   hold_addr_r, addr_s;
  logic [3:0]          hold_we_r, we_s;
  logic [31:0]         hold_wdata_r, wdata_s;
  logic                oe_s;
  logic                hold_s;

  // Issue decision: replay the held access, or grant imem/dmem, or go idle.
  always_comb begin
    owner_s  = owner_r;
    starve_s = starve_r;
    addr_s   = hold_addr_r;
    we_s     = hold_we_r;
    wdata_s  = hold_wdata_r;
    oe_s     = 1'b0;
    hold_s   = (owner_r != OWN_NONE) && !bus.mem_ready;
    if (rst) begin
      owner_s  = OWN_NONE;
      starve_s = STARVE_ZERO;
      we_s     = 4'b0000;
    end else if (hold_s) begin
      oe_s = 1'b1;
    end else if (bus.imem_oe && (!bus.dmem_oe || starve_r == STARVE_LIM)) begin
      oe_s     = 1'b1;
      owner_s  = OWN_IMEM;
      starve_s = STARVE_ZERO;
      addr_s   = ADDR_W'(bus.imem_addr);
      we_s     = 4'b0000;
      wdata_s  = bus.dmem_wdata;
    end else if (bus.dmem_oe) begin
      oe_s    = 1'b1;
      owner_s = OWN_DMEM;
      addr_s  = ADDR_W'(bus.dmem_addr);
      we_s    = bus.dmem_we;
      wdata_s = bus.dmem_wdata;
      if (!bus.imem_oe) begin
        starve_s = STARVE_ZERO;
      end else if (starve_r == STARVE_LIM) begin
        starve_s = starve_r;
      end else begin
        starve_s = starve_r + STARVE_ONE;
      end
    end else begin
      owner_s  = OWN_NONE;
      starve_s = STARVE_ZERO;
      we_s     = 4'b0000;
    end
  end

  // Owner, starvation count, request history and the replay copy of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r      <= OWN_NONE;
      starve_r     <= STARVE_ZERO;
      ireq_r       <= 1'b0;
      dreq_r       <= 1'b0;
      hold_addr_r  <= {ADDR_W{1'b0}};
      hold_we_r    <= 4'b0000;
      hold_wdata_r <= 32'h0000_0000;
    end else begin
      owner_r  <= owner_s;
      starve_r <= starve_s;
      ireq_r   <= bus.imem_oe;
      dreq_r   <= bus.dmem_oe;
      if (oe_s) begin
        hold_addr_r  <= addr_s;
        hold_we_r    <= we_s;
        hold_wdata_r <= wdata_s;
      end else begin
        hold_addr_r  <= hold_addr_r;
        hold_we_r    <= hold_we_r;
        hold_wdata_r <= hold_wdata_r;
      end
    end
  end

  assign bus.mem_oe    = oe_s;
  assign bus.mem_addr  = addr_s;
  assign bus.mem_we    = we_s;
  assign bus.mem_wdata = wdata_s;

  // A requester that lost arbitration last cycle sees ready=0 and holds its request.
  assign bus.imem_ready = !ireq_r || ((owner_r == OWN_IMEM) && bus.mem_ready);
  assign bus.dmem_ready = !dreq_r || ((owner_r == OWN_DMEM) && bus.mem_ready);
  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random core/memory
// traffic, checked against a per-cycle reference model and a store-count scoreboard.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model: in-flight owner (0 none, 1 imem, 2 dmem), lost-cycle count, copy of access
  int          m_own = 0;
  int          m_stv = 0;
  bit          m_pi  = 1'b0;
  bit          m_pd  = 1'b0;
  logic [31:0] m_ha  = 32'h0;
  logic [3:0]  m_hwe = 4'h0;
  logic [31:0] m_hwd = 32'h0;
  logic        cur_mr  = 1'b0;
  logic        cur_rst = 1'b1;

  // observations
  logic        obs_ir, obs_dr, obs_oe;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_we;
  logic        prev_oe_obs = 1'b0;
  logic [3:0]  prev_we_obs = 4'h0;
  int          acc_writes  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // first half of a cycle: memory response + reset, then the readies/rdata it produces
  task automatic phase_a(input logic r, input logic mr, input logic [31:0] mrd);
    rst           = r;
    bus.mem_ready = mr;
    bus.mem_rdata = mrd;
    cur_mr        = mr;
    cur_rst       = r;
    #1;
    obs_ir = bus.imem_ready;
    obs_dr = bus.dmem_ready;
    if (!r) begin
      chk("imem_ready", {31'h0, obs_ir}, {31'h0, (!m_pi || (m_own == 1 && mr))});
      chk("dmem_ready", {31'h0, obs_dr}, {31'h0, (!m_pd || (m_own == 2 && mr))});
      chk("imem_rdata", bus.imem_rdata, mrd);
      chk("dmem_rdata", bus.dmem_rdata, mrd);
      if (prev_oe_obs && prev_we_obs != 4'h0 && mr) acc_writes++;
    end
  endtask

  // second half: core requests, expected memory-side issue, then the clock edge
  task automatic phase_b(input logic iv, input logic [15:0] ia, input logic dv,
                         input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd);
    logic        e_oe;
    logic [31:0] e_a, e_wd;
    logic [3:0]  e_we;
    int          n_own, n_stv;
    bus.imem_oe    = iv;
    bus.imem_addr  = ia;
    bus.dmem_oe    = dv;
    bus.dmem_addr  = da;
    bus.dmem_we    = dwe;
    bus.dmem_wdata = dwd;
    #1;
    e_a = m_ha; e_we = m_hwe; e_wd = m_hwd;
    n_own = m_own; n_stv = m_stv;
    if (cur_rst) begin
      e_oe = 1'b0; e_we = 4'h0; n_own = 0; n_stv = 0;
    end else if (m_own != 0 && !cur_mr) begin
      e_oe = 1'b1;
    end else if (iv && (!dv || m_stv == STARVE_MAX)) begin
      e_oe = 1'b1; e_a = {16'h0, ia}; e_we = 4'h0; e_wd = dwd; n_own = 1; n_stv = 0;
    end else if (dv) begin
      e_oe = 1'b1; e_a = da; e_we = dwe; e_wd = dwd; n_own = 2;
      n_stv = !iv ? 0 : ((m_stv < STARVE_MAX) ? m_stv + 1 : STARVE_MAX);
    end else begin
      e_oe = 1'b0; e_we = 4'h0; n_own = 0; n_stv = 0;
    end
    obs_oe   = bus.mem_oe;
    obs_addr = bus.mem_addr;
    obs_we   = bus.mem_we;
    obs_wd   = bus.mem_wdata;
    chk("mem_oe", {31'h0, obs_oe}, {31'h0, e_oe});
    chk("mem_we", {28'h0, obs_we}, {28'h0, e_we});
    if (e_oe) chk("mem_addr", obs_addr, e_a);
    if (e_oe && e_we != 4'h0) chk("mem_wdata", obs_wd, e_wd);
    prev_oe_obs = obs_oe;
    prev_we_obs = obs_we;
    @(posedge clk);
    #1;
    if (cur_rst) begin
      m_ha = 32'h0; m_hwe = 4'h0; m_hwd = 32'h0;
      m_pi = 1'b0;  m_pd  = 1'b0;
    end else begin
      if (e_oe) begin m_ha = e_a; m_hwe = e_we; m_hwd = e_wd; end
      m_pi = iv; m_pd = dv;
    end
    m_own = n_own;
    m_stv = n_stv;
  endtask

  task automatic idle();
    phase_b(1'b0, 16'h0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] gmask;
    int          rcnt, rlast, acc0, core_writes, acc_base;
    bit          i_pend, d_pend;
    logic [15:0] i_a;
    logic [31:0] d_a, d_wd;
    logic [3:0]  d_we;
    logic        mr;

    // reset
    for (int k = 0; k < 2; k++) begin
      phase_a(1'b1, 1'b0, 32'h0);
      idle();
    end

    // single fetch
    phase_a(1'b0, 1'b1, 32'h1111_0000);
    phase_b(1'b1, 16'h0040, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("t1_addr", obs_addr, 32'h0000_0040);
    chk("t1_we", {28'h0, obs_we}, 32'h0);
    phase_a(1'b0, 1'b1, 32'hCAFE_0001);
    chk("t1_iready", {31'h0, obs_ir}, 32'h1);
    idle();

    // simultaneous requests: dmem first, imem next cycle
    phase_a(1'b0, 1'b1, 32'h0);
    phase_b(1'b1, 16'h0080, 1'b1, 32'h0000_1000, 4'h0, 32'h0);
    chk("t2_first_grant", obs_addr, 32'h0000_1000);
    phase_a(1'b0, 1'b1, 32'h2222_2222);
    chk("t2_dready", {31'h0, obs_dr}, 32'h1);
    chk("t2_iready_lost", {31'h0, obs_ir}, 32'h0);
    phase_b(1'b1, 16'h0080, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("t2_second_grant", obs_addr, 32'h0000_0080);
    phase_a(1'b0, 1'b1, 32'h3333_3333);
    chk("t2_iready", {31'h0, obs_ir}, 32'h1);
    idle();

    // starvation guard: D,D,D,D,I,D
    gmask = 32'h0; rcnt = 0; rlast = -1;
    for (int k = 0; k < 6; k++) begin
      phase_a(1'b0, 1'b1, $urandom);
      if (k > 0 && obs_ir) begin rcnt++; rlast = k; end
      phase_b(1'b1, 16'h0044, 1'b1, 32'h0000_3000, 4'h0, 32'h0);
      if (obs_addr == 32'h0000_3000) gmask = gmask | (32'h1 << k);
    end
    chk("t3_grants", gmask, 32'h0000_002F);
    chk("t3_iready_count", rcnt, 32'd1);
    chk("t3_iready_cycle", rlast, 32'd5);
    phase_a(1'b0, 1'b1, $urandom);
    phase_b(1'b1, 16'h0044, 1'b0, 32'h0, 4'h0, 32'h0);
    phase_a(1'b0, 1'b1, $urandom);
    idle();

    // store with two wait cycles
    phase_a(1'b0, 1'b1, 32'h0);
    phase_b(1'b0, 16'h0, 1'b1, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF);
    chk("t4_we", {28'h0, obs_we}, 32'h0000_000F);
    acc0 = acc_writes;
    for (int k = 0; k < 2; k++) begin
      phase_a(1'b0, 1'b0, 32'h0);
      chk("t4_dready_stall", {31'h0, obs_dr}, 32'h0);
      phase_b(1'b0, 16'h0, 1'b1, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF);
      chk("t4_replay_oe", {31'h0, obs_oe}, 32'h1);
      chk("t4_replay_addr", obs_addr, 32'h0000_2000);
      chk("t4_replay_wdata", obs_wd, 32'hDEAD_BEEF);
    end
    phase_a(1'b0, 1'b1, 32'h0);
    chk("t4_dready", {31'h0, obs_dr}, 32'h1);
    idle();
    phase_a(1'b0, 1'b1, 32'h0);
    chk("t4_one_write", acc_writes, acc0 + 1);
    idle();

    // reset while a store is stalled
    phase_a(1'b0, 1'b1, 32'h0);
    phase_b(1'b0, 16'h0, 1'b1, 32'h0000_2100, 4'h3, 32'h1234_5678);
    phase_a(1'b0, 1'b0, 32'h0);
    phase_b(1'b0, 16'h0, 1'b1, 32'h0000_2100, 4'h3, 32'h1234_5678);
    acc0 = acc_writes;
    phase_a(1'b1, 1'b0, 32'h0);
    phase_b(1'b0, 16'h0, 1'b1, 32'h0000_2100, 4'h3, 32'h1234_5678);
    chk("t5_oe_in_reset", {31'h0, obs_oe}, 32'h0);
    phase_a(1'b0, 1'b1, 32'h0);
    chk("t5_iready", {31'h0, obs_ir}, 32'h1);
    chk("t5_dready", {31'h0, obs_dr}, 32'h1);
    idle();
    chk("t5_oe_after", {31'h0, obs_oe}, 32'h0);
    chk("t5_no_write", acc_writes, acc0);

    // idle cycles
    for (int k = 0; k < 3; k++) begin
      phase_a(1'b0, 1'b1, $urandom);
      chk("t6_iready", {31'h0, obs_ir}, 32'h1);
      chk("t6_dready", {31'h0, obs_dr}, 32'h1);
      idle();
      chk("t6_oe", {31'h0, obs_oe}, 32'h0);
      chk("t6_we", {28'h0, obs_we}, 32'h0);
    end

    // random traffic
    i_pend = 1'b0; d_pend = 1'b0; core_writes = 0; acc_base = acc_writes;
    i_a = 16'h0; d_a = 32'h0; d_we = 4'h0; d_wd = 32'h0;
    for (int k = 0; k < 520; k++) begin
      mr = (k < 500) ? ($urandom_range(0, 3) != 0) : 1'b1;
      phase_a(1'b0, mr, $urandom);
      if (i_pend && obs_ir) i_pend = 1'b0;
      if (d_pend && obs_dr) begin
        if (d_we != 4'h0) core_writes++;
        d_pend = 1'b0;
      end
      if (k < 500 && !i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1; i_a = 16'($urandom);
      end
      if (k < 500 && !d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1'b1; d_a = $urandom; d_wd = $urandom;
        d_we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
      phase_b(i_pend, i_a, d_pend, d_a, d_we, d_wd);
    end
    chk("rnd_drained", {30'h0, i_pend, d_pend}, 32'h0);
    chk("rnd_store_count", acc_writes - acc_base, core_writes);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
